// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq
// Adds two 4*NIBBLES-bit operands by reusing one 4-bit generate/propagate
// slice once per clock. Nibble 0 (the least significant) is processed first.
// The carry between nibbles is held in a register.
//
// Handshake (both ports): a transfer happens on a rising edge where valid
// and ready are both high. The input side is ready only in IDLE. Once the
// output side raises out_valid, it holds the result stable until out_ready
// is seen. The requester keeps its operands stable until they are taken.
module nibble_serial_add_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  // idx needs at least one bit, even when there is a single nibble
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry_reg;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;

  // slice signals for the nibble currently selected by idx
  logic [3:0] a_n;
  logic [3:0] b_n;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s;
  logic       last;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == DONE);
  assign last     = (idx == IW'(NIBBLES - 1));

  // pick the active nibble from the latched operands
  always_comb begin
    a_n = 4'd0;
    b_n = 4'd0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) begin
        a_n = a_q[4*k +: 4];
        b_n = b_q[4*k +: 4];
      end
    end
  end

  // one 4-bit generate/propagate adder slice; the carry enters from carry_reg
  always_comb begin
    g    = a_n & b_n;
    p    = a_n ^ b_n;
    c    = 5'd0;
    c[0] = carry_reg;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (c[i] & p[i]);
    end
    s = p ^ c[3:0];
  end

  // sequencer: accept, run one nibble per clock, hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            carry_reg <= cin;
            idx       <= '0;
            sum       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IW'(k)) begin
              sum[4*k +: 4] <= s;
            end
          end
          carry_reg <= c[4];
          idx       <= idx + 1'b1;
          if (last) begin
            // on the top nibble, c[3] is the carry into the sign bit
            cout      <= c[4];
            ovf       <= c[3] ^ c[4];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq. It drives one 4-nibble instance and one
// 1-nibble instance, and checks both against an arithmetic reference model.
module tb_nibble_serial_add_seq;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-nibble instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, cout, ovf, busy;

  nibble_serial_add_seq #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  // 1-nibble instance
  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0, sum1;
  logic       cin1 = 1'b0, cout1, ovf1, busy1;

  nibble_serial_add_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  // scoreboard: expected {ovf, cout, sum}
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // reference: plain integer addition at width w
  function automatic logic [17:0] model(input int w, input longint x, input longint y, input longint ci);
    longint full, m, s;
    logic    co, ov, sx, sy, ss;
    m    = (longint'(1) << w);
    full = x + y + ci;
    s    = full % m;
    co   = (full >= m);
    sx   = ((x >> (w - 1)) & 1) != 0;
    sy   = ((y >> (w - 1)) & 1) != 0;
    ss   = ((s >> (w - 1)) & 1) != 0;
    ov   = (sx == sy) && (ss != sx);
    return {ov, co, 16'(s)};
  endfunction

  // driver: present operands on the 4-nibble instance, then scramble them during RUN
  task automatic start4(input logic [15:0] x, input logic [15:0] y, input logic ci);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    exp_q.push_back(model(16, longint'(x), longint'(y), longint'(ci)));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // wait for the result, check its latency and value
  task automatic wait_done4;
    int cnt;
    logic [17:0] e;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency4", 32'(cnt), 32'd4);
    e = exp_q.pop_front();
    chk("sum4", 32'(sum), 32'(e[15:0]));
    chk("cout4", 32'(cout), 32'(e[16]));
    chk("ovf4", 32'(ovf), 32'(e[17]));
  endtask

  // backpressure for hold cycles, then the handshake
  task automatic finish4(input int hold);
    logic [15:0] s0;
    logic c0, o0;
    s0 = sum; c0 = cout; o0 = ovf;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'({o0, c0, sum}), 32'({ovf, cout, s0}));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_dropped", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("sum_kept", 32'(sum), 32'(s0));
  endtask

  // full operation on the 1-nibble instance
  task automatic op1(input logic [3:0] x, input logic [3:0] y, input logic ci);
    int cnt;
    logic [17:0] e;
    e = model(4, longint'(x), longint'(y), longint'(ci));
    chk("in_ready1", 32'(in_ready1), 32'd1);
    a1 = x; b1 = y; cin1 = ci; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    cnt = 0;
    while (!out_valid1 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency1", 32'(cnt), 32'd1);
    chk("sum1", 32'(sum1), 32'(e[3:0]));
    chk("cout1", 32'(cout1), 32'(e[16]));
    chk("ovf1", 32'(ovf1), 32'(e[17]));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("valid1_dropped", 32'(out_valid1), 32'd0);
  endtask

  initial begin
    logic [17:0] e;
    logic [15:0] s0;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'({ovf, cout, sum}), 32'd0);

    // directed cases
    start4(16'h1234, 16'h4321, 1'b1); wait_done4; finish4(0);
    start4(16'hFFFF, 16'h0001, 1'b0); wait_done4; finish4(1);
    start4(16'h7FFF, 16'h0001, 1'b0); wait_done4; finish4(0);
    start4(16'h8000, 16'h8000, 1'b0); wait_done4; finish4(2);

    // backpressure with a pending request that must wait
    start4(16'h1111, 16'h2222, 1'b0); wait_done4;
    s0 = sum;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'(s0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(model(16, 1, 1, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", 32'(busy), 32'd1);
    wait_done4;
    finish4(0);

    // reset while RUN, at idx=2
    start4(16'hABCD, 16'h1357, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    e = exp_q.pop_front();
    chk("rst_run_ready", 32'(in_ready), 32'd1);
    chk("rst_run_valid", 32'(out_valid), 32'd0);
    chk("rst_run_busy", 32'(busy), 32'd0);
    chk("rst_run_sum", 32'({cout, sum}), 32'd0);
    start4(16'h0F0F, 16'h00F1, 1'b0); wait_done4; finish4(0);

    // randomized operations
    for (int i = 0; i < 12; i++) begin
      start4(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done4;
      finish4(int'($urandom_range(0, 3)));
    end

    // single-nibble instance
    op1(4'hF, 4'h1, 1'b1);
    op1(4'h7, 4'h1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      op1(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
